// File: rtl/uart_pkg.sv
// uart_pkg: shared scheduler state encoding and default byte width
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshakes, frame config, transmitter launch/busy and scheduler status
// master: requesters plus transmitter side; slave: the scheduler
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic cfg_par_en, cfg_par_type;
  logic [DATA_W-1:0] tx_p_data;
  logic tx_data_valid, tx_par_en, tx_par_type, tx_busy;
  logic sched_busy, to_err;
  logic [$clog2(N_REQ)-1:0] last_gnt;
  modport master (
    output req_valid, req_data, cfg_par_en, cfg_par_type, tx_busy,
    input req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_type, sched_busy, to_err, last_gnt
  );
  modport slave (
    input req_valid, req_data, cfg_par_en, cfg_par_type, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_type, sched_busy, to_err, last_gnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
// ports: req (request vector), ptr (search start) -> gnt (one-hot), idx (encoded winner), any (request present)
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // scan from farthest to nearest so the nearest requester above ptr overwrites last
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) idx = IDX_W'((int'(ptr) + i) % N_REQ);
  end
  assign any = |req;
  assign gnt = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N_REQ byte producers
// ports: clk, rst_n (async active-low), bus (slave side: requester handshakes, config, launch pulse, busy tracking, status)
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic clk,
  input logic rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, win;
  logic [N_REQ-1:0] gnt;
  logic any, grant, timeout;
  logic [CNT_W-1:0] cnt, cnt_inc;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  assign cnt_inc = cnt == CNT_W'(BUSY_TIMEOUT) ? cnt : cnt + CNT_W'(1);
  // the timeout fires in the cycle whose increment reaches the limit; a busy rise that cycle wins
  assign timeout = state == WAIT_BUSY && !bus.tx_busy && cnt_inc == CNT_W'(BUSY_TIMEOUT);
  assign bus.sched_busy = state != IDLE;
  assign bus.to_err = timeout;
  assign bus.tx_data_valid = state == LAUNCH;
  always_comb begin
    state_nxt = state;
    bus.req_ready = '0;
    grant = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = bus.tx_busy ? '0 : gnt;
        grant = any && !bus.tx_busy;
        state_nxt = grant ? LAUNCH : IDLE;
      end
      LAUNCH: state_nxt = WAIT_BUSY;
      WAIT_BUSY: state_nxt = bus.tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      default: state_nxt = bus.tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.tx_p_data <= '0;
      bus.tx_par_en <= 1'b0;
      bus.tx_par_type <= 1'b0;
      bus.last_gnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state == LAUNCH ? '0 : state == WAIT_BUSY ? cnt_inc : cnt;
      if (grant) begin
        bus.tx_p_data <= bus.req_data[win*DATA_W +: DATA_W];
        bus.tx_par_en <= bus.cfg_par_en;
        bus.tx_par_type <= bus.cfg_par_type;
        bus.last_gnt <= win;
        ptr <= win == IDX_W'(N_REQ - 1) ? '0 : win + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed vector table plus randomized traffic against a transaction-level model
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  uart_tx_sched_if #(.N_REQ(2), .DATA_W(8)) bus ();
  uart_tx_sched #(.N_REQ(2), .DATA_W(8), .BUSY_TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] vld;
    logic [7:0] d0, d1;
    logic pe, pt, busy;
    logic [1:0] rdy;
    logic dv;
    logic [7:0] dat;
    logic ope, opt, sb, to, lg;
  } vec_t;
  vec_t tv [30];
  function automatic vec_t mk(input logic [1:0] vld, input logic [7:0] d0, d1, input logic pe, pt, busy,
                              input logic [1:0] rdy, input logic dv, input logic [7:0] dat,
                              input logic ope, opt, sb, to, lg);
    vec_t v;
    v.vld = vld; v.d0 = d0; v.d1 = d1; v.pe = pe; v.pt = pt; v.busy = busy;
    v.rdy = rdy; v.dv = dv; v.dat = dat; v.ope = ope; v.opt = opt; v.sb = sb; v.to = to; v.lg = lg;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_all(input logic [1:0] rdy, input logic dv, input logic [7:0] dat,
                         input logic ope, opt, sb, to, lg);
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    chk("tx_data_valid", 32'(bus.tx_data_valid), 32'(dv));
    chk("tx_p_data", 32'(bus.tx_p_data), 32'(dat));
    chk("tx_par_en", 32'(bus.tx_par_en), 32'(ope));
    chk("tx_par_type", 32'(bus.tx_par_type), 32'(opt));
    chk("sched_busy", 32'(bus.sched_busy), 32'(sb));
    chk("to_err", 32'(bus.to_err), 32'(to));
    chk("last_gnt", 32'(bus.last_gnt), 32'(lg));
  endtask
  // random-phase model state
  logic [7:0] mem [2][64];
  int head [2];
  int tail [2];
  bit free;
  int launch_at, to_at, free_at, busy_from, busy_to, mptr, win, r;
  logic [7:0] m_dat;
  logic m_pe, m_pt, m_lg, c_pe, c_pt;
  logic [1:0] vld;
  initial begin
    tv[0]  = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[1]  = mk(2'b01, 8'hA5, 8'h00, 1, 0, 0, 2'b01, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[2]  = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'hA5, 1, 0, 1, 0, 0);
    tv[3]  = mk(2'b00, 8'h00, 8'h00, 0, 0, 1, 2'b00, 0, 8'hA5, 1, 0, 1, 0, 0);
    tv[4]  = mk(2'b10, 8'h00, 8'h3C, 0, 0, 1, 2'b00, 0, 8'hA5, 1, 0, 1, 0, 0);
    tv[5]  = mk(2'b10, 8'h00, 8'h3C, 0, 1, 1, 2'b00, 0, 8'hA5, 1, 0, 1, 0, 0);
    tv[6]  = mk(2'b10, 8'h00, 8'h3C, 0, 1, 0, 2'b00, 0, 8'hA5, 1, 0, 1, 0, 0);
    tv[7]  = mk(2'b10, 8'h00, 8'h3C, 1, 1, 0, 2'b10, 0, 8'hA5, 1, 0, 0, 0, 0);
    tv[8]  = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h3C, 1, 1, 1, 0, 1);
    tv[9]  = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h3C, 1, 1, 1, 0, 1);
    tv[10] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h3C, 1, 1, 1, 0, 1);
    tv[11] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h3C, 1, 1, 1, 0, 1);
    tv[12] = mk(2'b01, 8'h5A, 8'h00, 0, 0, 0, 2'b00, 0, 8'h3C, 1, 1, 1, 1, 1);
    tv[13] = mk(2'b01, 8'h5A, 8'h00, 0, 0, 1, 2'b00, 0, 8'h3C, 1, 1, 0, 0, 1);
    tv[14] = mk(2'b11, 8'h5A, 8'h77, 0, 1, 0, 2'b01, 0, 8'h3C, 1, 1, 0, 0, 1);
    tv[15] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 0, 2'b00, 1, 8'h5A, 0, 1, 1, 0, 0);
    tv[16] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 0, 2'b00, 0, 8'h5A, 0, 1, 1, 0, 0);
    tv[17] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 0, 2'b00, 0, 8'h5A, 0, 1, 1, 0, 0);
    tv[18] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 0, 2'b00, 0, 8'h5A, 0, 1, 1, 0, 0);
    tv[19] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 1, 2'b00, 0, 8'h5A, 0, 1, 1, 0, 0);
    tv[20] = mk(2'b11, 8'h5A, 8'h77, 1, 0, 0, 2'b00, 0, 8'h5A, 0, 1, 1, 0, 0);
    tv[21] = mk(2'b11, 8'h5A, 8'h77, 1, 1, 0, 2'b10, 0, 8'h5A, 0, 1, 0, 0, 0);
    tv[22] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h77, 1, 1, 1, 0, 1);
    tv[23] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h77, 1, 1, 1, 0, 1);
    tv[24] = mk(2'b00, 8'h00, 8'h00, 0, 0, 1, 2'b00, 0, 8'h77, 1, 1, 1, 0, 1);
    tv[25] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h77, 1, 1, 1, 0, 1);
    tv[26] = mk(2'b01, 8'hC3, 8'h00, 1, 1, 0, 2'b01, 0, 8'h77, 1, 1, 0, 0, 1);
    tv[27] = mk(2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'hC3, 1, 1, 1, 0, 0);
    tv[28] = mk(2'b00, 8'h00, 8'h00, 0, 0, 1, 2'b00, 0, 8'hC3, 1, 1, 1, 0, 0);
    tv[29] = mk(2'b11, 8'h11, 8'h22, 0, 0, 1, 2'b00, 0, 8'hC3, 1, 1, 1, 0, 0);
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.cfg_par_en = 1'b0;
    bus.cfg_par_type = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_all(2'b00, 0, 8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc = i;
      bus.req_valid = tv[i].vld;
      bus.req_data = {tv[i].d1, tv[i].d0};
      bus.cfg_par_en = tv[i].pe;
      bus.cfg_par_type = tv[i].pt;
      bus.tx_busy = tv[i].busy;
      #1;
      chk_all(tv[i].rdy, tv[i].dv, tv[i].dat, tv[i].ope, tv[i].opt, tv[i].sb, tv[i].to, tv[i].lg);
    end
    // asynchronous reset during WAIT_DONE, then a tie must go to requester 0
    @(negedge clk);
    cyc = 30;
    bus.req_valid = '0;
    #1;
    chk("pre_reset_busy", 32'(bus.sched_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all(2'b00, 0, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_busy = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("tie_after_reset", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // randomized traffic checked against a frame-level model
    for (int k = 0; k < 2; k++) begin
      head[k] = 0;
      tail[k] = 40;
      for (int j = 0; j < 64; j++) mem[k][j] = 8'($urandom);
    end
    free = 1'b1;
    launch_at = -1; to_at = -1; free_at = -1; busy_from = 0; busy_to = 0; mptr = 0;
    m_dat = '0; m_pe = 0; m_pt = 0; m_lg = 0;
    cyc = 0;
    while (cyc < 4000 && !(free && head[0] == tail[0] && head[1] == tail[1])) begin
      @(negedge clk);
      if (!free && cyc == free_at) free = 1'b1;
      bus.tx_busy = free ? ($urandom_range(0, 4) == 0) : (cyc >= busy_from && cyc < busy_to);
      for (int k = 0; k < 2; k++) vld[k] = head[k] != tail[k] && $urandom_range(0, 3) != 0;
      bus.req_valid = vld;
      bus.req_data = {mem[1][head[1]], mem[0][head[0]]};
      c_pe = 1'($urandom);
      c_pt = 1'($urandom);
      bus.cfg_par_en = c_pe;
      bus.cfg_par_type = c_pt;
      #1;
      win = -1;
      if (free && !bus.tx_busy)
        for (int k = 0; k < 2; k++) if (win < 0 && vld[(mptr + k) % 2]) win = (mptr + k) % 2;
      chk_all(win < 0 ? 2'b00 : 2'b01 << win, !free && cyc == launch_at, m_dat, m_pe, m_pt,
              !free, !free && cyc == to_at, m_lg);
      if (win >= 0) begin
        m_dat = mem[win][head[win]];
        head[win]++;
        m_pe = c_pe;
        m_pt = c_pt;
        m_lg = 1'(win);
        mptr = (win + 1) % 2;
        free = 1'b0;
        launch_at = cyc + 1;
        r = $urandom_range(0, 4);
        if (r == 4) begin
          busy_from = 0; busy_to = 0;
          to_at = launch_at + 4;
          free_at = launch_at + 5;
        end else begin
          busy_from = launch_at + r + 1;
          busy_to = busy_from + $urandom_range(1, 4);
          to_at = -1;
          free_at = busy_to + 1;
        end
      end
      cyc++;
    end
    chk("drained", 32'(tail[0] - head[0] + tail[1] - head[1]), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares the single UART transmitter between `N_REQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and launches each byte as a one-cycle `DATA_VALID` pulse with frozen parity configuration. It then tracks the transmitter's `BUSY` through the frame and flags a transmitter that never starts. It sits directly in front of the UART transmit path in the SoC.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥2)
- `DATA_W`, 8, byte width; must match the transmitter's `P_DATA`
- `BUSY_TIMEOUT`, 4, max cycles after launch to wait for `TX_BUSY` rising

Ports:
- `CLK`  in  1  single clock; all state on rising edge
- `RST`  in  1  asynchronous, active-low reset
- `REQ_VALID`  in  N_REQ  per-requester byte valid
- `REQ_DATA`  in  N_REQ*DATA_W  packed bytes; requester i at `[i*DATA_W +: DATA_W]`
- `REQ_READY`  out  N_REQ  one-hot grant; handshake when VALID&READY at a clock edge
- `CFG_PAR_EN`  in  1  parity enable, sampled at grant
- `CFG_PAR_TYPE`  in  1  parity type, sampled at grant
- `TX_P_DATA`  out  DATA_W  byte to transmitter
- `TX_DATA_VALID`  out  1  one-cycle launch pulse
- `TX_PAR_EN`, `TX_PAR_TYPE`  out  1  frozen frame configuration
- `TX_BUSY`  in  1  transmitter busy
- `SCHED_BUSY`  out  1  high in any state other than IDLE
- `LAST_GNT`  out  $clog2(N_REQ)  index of last granted requester
- `TO_ERR`  out  1  one-cycle pulse on launch timeout

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any `REQ_VALID` and `TX_BUSY`=0, `REQ_READY` is driven combinationally, one-hot to the round-robin winner.
  - On the handshake edge, latch the winner's byte into `TX_P_DATA`, latch CFG into `TX_PAR_*`, update `LAST_GNT`, set pointer = winner+1 mod N_REQ, and go to LAUNCH.
- Round robin: search from the pointer upward with wrap. The pointer resets to 0 and moves only on a grant.
- LAUNCH: `TX_DATA_VALID`=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - `TX_BUSY`=1 → go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, pulse `TO_ERR` and go to IDLE.
- WAIT_DONE: when `TX_BUSY`=0, go to IDLE.
- `REQ_READY` is 0 in every state except IDLE. `REQ_READY` is 0 in IDLE while `TX_BUSY`=1.
- `TX_P_DATA` and `TX_PAR_*` are held until the next grant. CFG changes mid-frame have no effect.
- Counter width is $clog2(BUSY_TIMEOUT+1). It saturates and never wraps.
- A requester dropping `REQ_VALID` without a handshake loses nothing; no grant is recorded.

## Timing
- Reset values:
  - All outputs 0, state IDLE, pointer 0.
  - `REQ_READY` is 0 because no valid requests exist during reset.
- Latency: handshake at edge k → `TX_DATA_VALID` high during cycle k+1.
- Minimum spacing: one IDLE cycle after `TX_BUSY` falls before the next grant. The next grant can be the cycle `TX_BUSY` is seen low in IDLE.
- Simultaneous valid requests: exactly one is granted; the other keeps waiting without loss.
- Timeout:
  - `TO_ERR` is asserted in the cycle the counter hits `BUSY_TIMEOUT`; IDLE follows the next cycle.
  - A `TX_BUSY` rising in that same cycle takes priority → WAIT_DONE, no error.
- Reset mid-frame: `TX_DATA_VALID`, `REQ_READY`, and `SCHED_BUSY` fall immediately (async). The in-flight byte is dropped. The transmitter shares the reset.

## Structure
- Shared package `uart_pkg`: state enum (`IDLE`/`LAUNCH`/`WAIT_BUSY`/`WAIT_DONE`) and the `DATA_W` default constant.
- One sub-module, `rr_arbiter`:
  - Combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, any-request flag.
- FSM, counter, and holding registers stay in the top-level module.

## Test plan
- Single request: req0 sends 0xA5 with PAR_EN=1, TYPE=0 → `REQ_READY[0]` high one cycle; next cycle `TX_DATA_VALID`=1 with `TX_P_DATA`=0xA5, `TX_PAR_EN`=1; `SCHED_BUSY` holds until `TX_BUSY` falls.
- Contention: both requesters valid continuously with 0x11/0x22 → grants alternate 0,1,0,1; `LAST_GNT` follows; no byte duplicated or lost over 8 frames.
- Config freeze: toggle `CFG_PAR_TYPE` during WAIT_DONE → `TX_PAR_TYPE` unchanged until the next grant.
- Timeout: `TX_BUSY` held 0 after launch → `TO_ERR` pulses exactly 4 cycles after LAUNCH; FSM returns to IDLE; the next request is served normally.
- Transmitter busy at idle: `TX_BUSY`=1 with requests pending → `REQ_READY`=0 until `TX_BUSY` falls.
- Reset mid-frame: assert `RST`=0 during WAIT_DONE → all outputs 0 asynchronously; after release, pointer=0 and req0 wins a tie.
